// File: rtl/cmd_tiled_frame_sequencer.sv
// Tiled frame sequencer: walks a rectangular window of tiles, issuing one
// encoder start per tile (gated on buffer readiness) and waiting for enc_done
// before advancing along the tile row, then down to the next tile row.
module cmd_tiled_frame_sequencer #(
    parameter int ADDRESS_NUMBER   = 15,
    parameter int COLADDR_NUMBER   = 10,
    parameter int FRAME_WIDTH_BITS = 13,
    parameter int TILES_BITS       = 8
) (
    input  logic                                      clk,
    input  logic                                      mrst_n,
    input  logic                                      cfg_start,
    input  logic                                      cfg_write,
    input  logic [ADDRESS_NUMBER+COLADDR_NUMBER-1:0]  cfg_frame_la,
    input  logic [FRAME_WIDTH_BITS:0]                 cfg_line_inc,
    input  logic [FRAME_WIDTH_BITS:0]                 cfg_hstep,
    input  logic [5:0]                                cfg_vstep,
    input  logic [TILES_BITS-1:0]                     cfg_tiles_x_m1,
    input  logic [TILES_BITS-1:0]                     cfg_tiles_y_m1,
    input  logic                                      abort,
    input  logic                                      buf_ready,
    input  logic                                      enc_done,
    output logic                                      start_rd,
    output logic                                      start_wr,
    output logic [2:0]                                start_bank,
    output logic [COLADDR_NUMBER-4:0]                 start_col,
    output logic [ADDRESS_NUMBER-1:0]                 start_row,
    output logic                                      busy,
    output logic [TILES_BITS-1:0]                     tile_x,
    output logic [TILES_BITS-1:0]                     tile_y,
    output logic                                      frame_done,
    output logic                                      aborted
);
    localparam int AW = ADDRESS_NUMBER + COLADDR_NUMBER;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUF,
        ST_START,
        ST_BUSY,
        ST_ADVANCE
    } state_t;

    state_t                  r_state;
    logic                    r_write;
    logic [AW-1:0]           r_tile_la;
    logic [AW-1:0]           r_line_la;
    logic [AW-1:0]           r_vinc;
    logic [AW-1:0]           r_hstep;
    logic [TILES_BITS-1:0]   r_tx_m1;
    logic [TILES_BITS-1:0]   r_ty_m1;
    logic [TILES_BITS-1:0]   r_tile_x;
    logic [TILES_BITS-1:0]   r_tile_y;
    logic                    r_abort;
    logic                    r_start_rd;
    logic                    r_start_wr;
    logic [2:0]              r_bank;
    logic [COLADDR_NUMBER-4:0] r_col;
    logic [ADDRESS_NUMBER-1:0] r_row;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_aborted;

    logic [AW-1:0]           w_vinc;
    logic [AW-1:0]           w_next_line;
    logic                    w_last;
    logic                    w_abort;

    // vstep lines worth of LA, modulo 2^AW
    assign w_vinc      = AW'(cfg_vstep) * AW'(cfg_line_inc);
    assign w_next_line = r_line_la + r_vinc;
    assign w_last      = (r_tile_x == r_tx_m1) && (r_tile_y == r_ty_m1);
    // an abort arriving in the deciding cycle counts the same as a latched one
    assign w_abort     = r_abort | abort;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_tile_la    <= '0;
            r_line_la    <= '0;
            r_vinc       <= '0;
            r_hstep      <= '0;
            r_tx_m1      <= '0;
            r_ty_m1      <= '0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_abort      <= 1'b0;
            r_start_rd   <= 1'b0;
            r_start_wr   <= 1'b0;
            r_bank       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_start_rd   <= 1'b0;
            r_start_wr   <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
            // latch set precedes the case so that an IDLE-entry clear below wins
            if (r_state != ST_IDLE && abort)
                r_abort <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_abort <= 1'b0;
                    if (cfg_start) begin
                        r_write   <= cfg_write;
                        r_tile_la <= cfg_frame_la;
                        r_line_la <= cfg_frame_la;
                        r_vinc    <= w_vinc;
                        r_hstep   <= AW'(cfg_hstep);
                        r_tx_m1   <= cfg_tiles_x_m1;
                        r_ty_m1   <= cfg_tiles_y_m1;
                        r_tile_x  <= '0;
                        r_tile_y  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_WAIT_BUF;
                    end
                end
                ST_WAIT_BUF: begin
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_abort   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (buf_ready) begin
                        r_start_rd <= ~r_write;
                        r_start_wr <= r_write;
                        r_bank     <= r_tile_la[2:0];
                        r_col      <= r_tile_la[COLADDR_NUMBER-1:3];
                        r_row      <= r_tile_la[AW-1:COLADDR_NUMBER];
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (enc_done)
                        r_state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (w_last) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_abort      <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_abort) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_abort   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_tile_x == r_tx_m1) begin
                        r_tile_x  <= '0;
                        r_tile_y  <= r_tile_y + 1'b1;
                        r_line_la <= w_next_line;
                        r_tile_la <= w_next_line;
                        r_state   <= ST_WAIT_BUF;
                    end else begin
                        r_tile_x  <= r_tile_x + 1'b1;
                        r_tile_la <= r_tile_la + r_hstep;
                        r_state   <= ST_WAIT_BUF;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_rd   = r_start_rd;
    assign start_wr   = r_start_wr;
    assign start_bank = r_bank;
    assign start_col  = r_col;
    assign start_row  = r_row;
    assign busy       = r_busy;
    assign tile_x     = r_tile_x;
    assign tile_y     = r_tile_y;
    assign frame_done = r_frame_done;
    assign aborted    = r_aborted;

endmodule

// File: tb/tb_cmd_tiled_frame_sequencer.sv
// Directed bench for cmd_tiled_frame_sequencer: drives frames, models the
// encoder's enc_done response, and compares issued tile LAs and pulses
// against hand-computed values.
module tb_cmd_tiled_frame_sequencer;
    localparam int AW = 25;

    logic          clk;
    logic          mrst_n;
    logic          cfg_start;
    logic          cfg_write;
    logic [AW-1:0] cfg_frame_la;
    logic [13:0]   cfg_line_inc;
    logic [13:0]   cfg_hstep;
    logic [5:0]    cfg_vstep;
    logic [7:0]    cfg_tiles_x_m1;
    logic [7:0]    cfg_tiles_y_m1;
    logic          abort;
    logic          buf_ready;
    logic          enc_done;
    logic          start_rd;
    logic          start_wr;
    logic [2:0]    start_bank;
    logic [6:0]    start_col;
    logic [14:0]   start_row;
    logic          busy;
    logic [7:0]    tile_x;
    logic [7:0]    tile_y;
    logic          frame_done;
    logic          aborted;

    cmd_tiled_frame_sequencer #(
        .ADDRESS_NUMBER  (15),
        .COLADDR_NUMBER  (10),
        .FRAME_WIDTH_BITS(13),
        .TILES_BITS      (8)
    ) dut (
        .clk           (clk),
        .mrst_n        (mrst_n),
        .cfg_start     (cfg_start),
        .cfg_write     (cfg_write),
        .cfg_frame_la  (cfg_frame_la),
        .cfg_line_inc  (cfg_line_inc),
        .cfg_hstep     (cfg_hstep),
        .cfg_vstep     (cfg_vstep),
        .cfg_tiles_x_m1(cfg_tiles_x_m1),
        .cfg_tiles_y_m1(cfg_tiles_y_m1),
        .abort         (abort),
        .buf_ready     (buf_ready),
        .enc_done      (enc_done),
        .start_rd      (start_rd),
        .start_wr      (start_wr),
        .start_bank    (start_bank),
        .start_col     (start_col),
        .start_row     (start_row),
        .busy          (busy),
        .tile_x        (tile_x),
        .tile_y        (tile_y),
        .frame_done    (frame_done),
        .aborted       (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    int            enc_cnt;
    int            enc_delay;
    int            last_done_cyc;
    int            gap;
    int            n_rd, n_wr, n_fd, n_ab;
    logic          busy_at_fd;
    logic [AW-1:0] las[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        las.delete();
        n_rd = 0; n_wr = 0; n_fd = 0; n_ab = 0;
        enc_cnt = -1; last_done_cyc = -1; gap = -1;
        busy_at_fd = 1'b1;
    endtask

    // One cycle: advance to the falling edge, drop pulses, observe outputs, model encoder
    task automatic tick();
        @(negedge clk);
        cyc++;
        cfg_start = 1'b0;
        abort     = 1'b0;
        enc_done  = 1'b0;
        if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) begin
                enc_done      = 1'b1;
                last_done_cyc = cyc;
                enc_cnt       = -1;
            end
        end
        if (start_rd | start_wr) begin
            las.push_back({start_row, start_col, start_bank});
            n_rd += int'(start_rd);
            n_wr += int'(start_wr);
            if (last_done_cyc >= 0) gap = cyc - last_done_cyc;
            enc_cnt = enc_delay;
        end
        if (frame_done) begin n_fd++; busy_at_fd = busy; end
        if (aborted) n_ab++;
    endtask

    task automatic run(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin done = 1'b1; break; end
        end
        check_eq("frame_ends", 32'(done), 32'd1);
    endtask

    task automatic setcfg(input logic wr, input logic [AW-1:0] la, input logic [13:0] hs,
                          input logic [13:0] li, input logic [5:0] vs,
                          input logic [7:0] xm1, input logic [7:0] ym1);
        cfg_write      = wr;
        cfg_frame_la   = la;
        cfg_hstep      = hs;
        cfg_line_inc   = li;
        cfg_vstep      = vs;
        cfg_tiles_x_m1 = xm1;
        cfg_tiles_y_m1 = ym1;
    endtask

    initial begin
        mrst_n = 1'b0; cfg_start = 1'b0; abort = 1'b0; buf_ready = 1'b1; enc_done = 1'b0;
        setcfg(1'b0, '0, '0, '0, '0, '0, '0);
        enc_delay = 2;
        clear_mon();
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'({start_rd, start_wr}), 32'd0);
        check_eq("rst_pulses", 32'({frame_done, aborted}), 32'd0);
        check_eq("rst_addr", 32'({start_row, start_col, start_bank}), 32'd0);
        check_eq("rst_tiles", 32'({tile_x, tile_y}), 32'd0);
        mrst_n = 1'b1;
        tick();

        // 2x2 read frame, start latency and enc_done-to-start latency
        clear_mon();
        setcfg(1'b0, 25'h1000, 14'd4, 14'h200, 6'd16, 8'd1, 8'd1);
        cfg_start = 1'b1;
        tick();
        check_eq("lat_busy", 32'(busy), 32'd1);
        check_eq("lat_c1_idle", 32'(start_rd), 32'd0);
        tick();
        check_eq("lat_c2_start", 32'(start_rd), 32'd1);
        run(200);
        check_eq("rd_count", 32'(las.size()), 32'd4);
        if (las.size() == 4) begin
            check_eq("rd_la0", 32'(las[0]), 32'h1000);
            check_eq("rd_la1", 32'(las[1]), 32'h1004);
            check_eq("rd_la2", 32'(las[2]), 32'h3000);
            check_eq("rd_la3", 32'(las[3]), 32'h3004);
        end
        check_eq("rd_nwr", 32'(n_wr), 32'd0);
        check_eq("rd_fdone", 32'(n_fd), 32'd1);
        check_eq("rd_aborted", 32'(n_ab), 32'd0);
        check_eq("rd_busy_at_fd", 32'(busy_at_fd), 32'd0);
        check_eq("done_to_start", 32'(gap), 32'd3);
        check_eq("rd_last_tile", 32'({tile_x, tile_y}), 32'h0101);

        // same frame, write direction
        clear_mon();
        setcfg(1'b1, 25'h1000, 14'd4, 14'h200, 6'd16, 8'd1, 8'd1);
        cfg_start = 1'b1;
        run(200);
        check_eq("wr_nwr", 32'(n_wr), 32'd4);
        check_eq("wr_nrd", 32'(n_rd), 32'd0);
        check_eq("wr_fdone", 32'(n_fd), 32'd1);
        if (las.size() == 4) check_eq("wr_la3", 32'(las[3]), 32'h3004);

        // buffer not ready holds the tile back
        clear_mon();
        setcfg(1'b0, 25'h0808, 14'd4, 14'h200, 6'd1, 8'd0, 8'd0);
        buf_ready = 1'b0;
        cfg_start = 1'b1;
        tick();
        repeat (20) tick();
        check_eq("nobuf_nostart", 32'(n_rd + n_wr), 32'd0);
        buf_ready = 1'b1;
        tick();
        check_eq("buf_first_cycle", 32'(start_rd), 32'd1);
        check_eq("buf_la", 32'({start_row, start_col, start_bank}), 32'h0808);
        run(100);
        check_eq("buf_fdone", 32'(n_fd), 32'd1);

        // abort during tile 1 of a 3x1 frame
        clear_mon();
        enc_delay = 4;
        setcfg(1'b0, 25'h2000, 14'd8, 14'h200, 6'd1, 8'd2, 8'd0);
        cfg_start = 1'b1;
        for (int i = 0; i < 100 && las.size() < 2; i++) tick();
        tick();
        abort = 1'b1;
        run(100);
        check_eq("ab_tiles", 32'(las.size()), 32'd2);
        check_eq("ab_pulse", 32'(n_ab), 32'd1);
        check_eq("ab_fdone", 32'(n_fd), 32'd0);
        enc_delay = 2;

        // cfg_start while busy is ignored
        clear_mon();
        setcfg(1'b0, 25'h1000, 14'd4, 14'h200, 6'd16, 8'd1, 8'd1);
        cfg_start = 1'b1;
        for (int i = 0; i < 100 && las.size() < 1; i++) tick();
        tick();
        setcfg(1'b1, 25'h8000, 14'd40, 14'h100, 6'd2, 8'd0, 8'd0);
        cfg_start = 1'b1;
        run(200);
        check_eq("rest_count", 32'(las.size()), 32'd4);
        if (las.size() == 4) begin
            check_eq("rest_la1", 32'(las[1]), 32'h1004);
            check_eq("rest_la3", 32'(las[3]), 32'h3004);
        end
        check_eq("rest_nwr", 32'(n_wr), 32'd0);

        // LA wrap past top of memory
        clear_mon();
        setcfg(1'b0, 25'h1FFFFFE, 14'd4, 14'h200, 6'd1, 8'd1, 8'd0);
        cfg_start = 1'b1;
        run(200);
        check_eq("wrap_count", 32'(las.size()), 32'd2);
        if (las.size() == 2) begin
            check_eq("wrap_la0", 32'(las[0]), 32'h1FFFFFE);
            check_eq("wrap_la1", 32'(las[1]), 32'h2);
        end

        // reset in the middle of BUSY
        clear_mon();
        enc_delay = 10;
        setcfg(1'b0, 25'h0C0D, 14'd4, 14'h200, 6'd1, 8'd1, 8'd0);
        cfg_start = 1'b1;
        for (int i = 0; i < 100 && las.size() < 1; i++) tick();
        tick();
        mrst_n = 1'b0;
        tick();
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_addr", 32'({start_row, start_col, start_bank}), 32'd0);
        mrst_n = 1'b1;
        repeat (20) tick();
        check_eq("mrst_idle_nostart", 32'(las.size()), 32'd1);
        check_eq("mrst_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
